// File: rtl/present_mode_core.sv
// Iterative PRESENT-64 encryptor (80/128-bit key), one round per clock, with
// runtime-selectable ECB/CBC/CTR chaining and valid/ready handshakes on both sides.
module present_mode_core #(
  parameter int unsigned KEY_W = 80
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       i_mode,
  input  logic [KEY_W-1:0] i_key,
  input  logic             i_iv_load,
  input  logic [63:0]      i_iv,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [63:0]      i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [63:0]      o_out_data,
  output logic             o_busy
);

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("present_mode_core: KEY_W must be 80 or 128");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MODE_CBC = 2'b01;
  localparam logic [1:0] MODE_CTR = 2'b10;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[(i % 4) * 16 + i / 4] = x[i];
    return y;
  endfunction

  logic [1:0]       r_state;
  logic [5:0]       r_rc;
  logic [1:0]       r_mode;
  logic [KEY_W-1:0] r_key;
  logic [63:0]      r_s;
  logic [63:0]      r_pt;
  logic [63:0]      r_chain;
  logic [63:0]      r_out_data;

  logic             w_accept;
  logic [63:0]      w_chain_in;
  logic [63:0]      w_s_load;
  logic [63:0]      w_round_key;
  logic [63:0]      w_round_out;
  logic [KEY_W-1:0] w_key_rot;
  logic [KEY_W-1:0] w_key_next;
  logic [63:0]      w_cipher;
  logic [63:0]      w_out;
  logic [63:0]      w_chain_next;

  assign w_accept    = (r_state == ST_IDLE) && i_in_valid;
  // A same-cycle iv_load must already apply to the block being accepted.
  assign w_chain_in  = i_iv_load ? i_iv : r_chain;
  assign w_round_key = r_key[KEY_W-1 -: 64];
  assign w_round_out = p_layer(s_layer(r_s ^ w_round_key));
  assign w_key_rot   = {r_key[KEY_W-62:0], r_key[KEY_W-1:KEY_W-61]};
  assign w_cipher    = r_s ^ w_round_key;

  if (KEY_W == 80) begin : g_k80
    always_comb begin
      w_key_next         = w_key_rot;
      w_key_next[79:76]  = sbox(w_key_rot[79:76]);
      w_key_next[19:15]  = w_key_rot[19:15] ^ r_rc[4:0];
    end
  end else begin : g_k128
    always_comb begin
      w_key_next           = w_key_rot;
      w_key_next[127:124]  = sbox(w_key_rot[127:124]);
      w_key_next[123:120]  = sbox(w_key_rot[123:120]);
      w_key_next[66:62]    = w_key_rot[66:62] ^ r_rc[4:0];
    end
  end

  always_comb begin
    w_s_load = i_in_data;
    case (i_mode)
      MODE_CBC: w_s_load = i_in_data ^ w_chain_in;
      MODE_CTR: w_s_load = w_chain_in;
      default:  w_s_load = i_in_data;
    endcase
  end

  always_comb begin
    w_out        = w_cipher;
    w_chain_next = r_chain;
    case (r_mode)
      MODE_CBC: w_chain_next = w_cipher;
      MODE_CTR: begin
        w_out        = w_cipher ^ r_pt;
        w_chain_next = r_chain + 64'd1;
      end
      default: ;
    endcase
  end

  // Control and architecturally visible state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rc       <= 6'd0;
      r_chain    <= 64'd0;
      r_out_data <= 64'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_iv_load) r_chain <= i_iv;
          if (i_in_valid) begin
            r_state <= ST_RUN;
            r_rc    <= 6'd1;
          end
        end
        ST_RUN: begin
          // rc==32 is the final whitening step after round 31.
          if (r_rc == 6'd32) begin
            r_out_data <= w_out;
            r_chain    <= w_chain_next;
            r_state    <= ST_DONE;
            r_rc       <= 6'd0;
          end else begin
            r_rc <= r_rc + 6'd1;
          end
        end
        ST_DONE: begin
          if (i_out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Datapath registers; contents are don't-care outside an accepted block.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mode <= i_mode;
      r_key  <= i_key;
      r_pt   <= i_in_data;
      r_s    <= w_s_load;
    end else if (r_state == ST_RUN && !r_rc[5]) begin
      r_s   <= w_round_out;
      r_key <= w_key_next;
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_out_valid = (r_state == ST_DONE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_out_data  = r_out_data;

endmodule
